// File: rtl/regfile_pkg.sv
// Shared constants and types for the architectural register file.
package regfile_pkg;

   localparam int unsigned XLEN  = 32;
   localparam int unsigned NREGS = 32;
   localparam int unsigned AW    = $clog2(NREGS);

   typedef logic [AW-1:0]   reg_addr_t;
   typedef logic [XLEN-1:0] xlen_t;

   localparam reg_addr_t REG_ZERO = '0;

endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-producer scoreboard: one bit per architectural register except x0.
// An issue and a writeback to the same register in one cycle leave the bit set.
module regfile_scoreboard
   import regfile_pkg::*;
#(
   parameter int unsigned NREGS = regfile_pkg::NREGS,
   parameter int unsigned AW    = $clog2(NREGS)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             issue_en,
   input  logic [AW-1:0]    issue_rd,
   input  logic             we,
   input  logic [AW-1:0]    rd_addr,
   output logic [NREGS-1:1] pending
);

   always_ff @(posedge clk) begin
      if (rst) begin
         pending <= '0;
      end else begin
         if (we && rd_addr != REG_ZERO)
            pending[rd_addr] <= 1'b0;
         // Issue is assigned last so a newer producer outlives a same-cycle writeback.
         if (issue_en && issue_rd != REG_ZERO)
            pending[issue_rd] <= 1'b1;
      end
   end

endmodule

// File: rtl/regfile.sv
// Integer register file: two combinational read ports, one write port, pending scoreboard.
// Define REGFILE_BYPASS_EN to forward same-cycle writeback data to the read ports.
module regfile
   import regfile_pkg::*;
#(
   parameter int unsigned XLEN  = regfile_pkg::XLEN,
   parameter int unsigned NREGS = regfile_pkg::NREGS,
   parameter int unsigned AW    = $clog2(NREGS)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [AW-1:0]   rs1_addr,
   output logic [XLEN-1:0] rs1_data,
   output logic            rs1_busy,
   input  logic [AW-1:0]   rs2_addr,
   output logic [XLEN-1:0] rs2_data,
   output logic            rs2_busy,
   input  logic            issue_en,
   input  logic [AW-1:0]   issue_rd,
   input  logic            we,
   input  logic [AW-1:0]   rd_addr,
   input  logic [XLEN-1:0] rd_data
);

   logic [XLEN-1:0]  regs [1:NREGS-1];
   logic [NREGS-1:1] pending;

   regfile_scoreboard #(
      .NREGS (NREGS),
      .AW    (AW)
   ) u_scoreboard (
      .clk      (clk),
      .rst      (rst),
      .issue_en (issue_en),
      .issue_rd (issue_rd),
      .we       (we),
      .rd_addr  (rd_addr),
      .pending  (pending)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int unsigned i = 1; i < NREGS; i++)
            regs[i] <= '0;
      end else if (we && rd_addr != REG_ZERO) begin
         regs[rd_addr] <= rd_data;
      end
   end

`ifdef REGFILE_BYPASS_EN
   logic wr_live;
   logic wr_reissued;

   assign wr_live     = we && rd_addr != REG_ZERO;
   assign wr_reissued = issue_en && issue_rd == rd_addr;
`endif

   always_comb begin
      rs1_data = '0;
      rs1_busy = 1'b0;
      if (rs1_addr != REG_ZERO) begin
         rs1_data = regs[rs1_addr];
         rs1_busy = pending[rs1_addr];
      end
`ifdef REGFILE_BYPASS_EN
      if (wr_live && rs1_addr == rd_addr) begin
         rs1_data = rd_data;
         if (!wr_reissued)
            rs1_busy = 1'b0;
      end
`endif
   end

   always_comb begin
      rs2_data = '0;
      rs2_busy = 1'b0;
      if (rs2_addr != REG_ZERO) begin
         rs2_data = regs[rs2_addr];
         rs2_busy = pending[rs2_addr];
      end
`ifdef REGFILE_BYPASS_EN
      if (wr_live && rs2_addr == rd_addr) begin
         rs2_data = rd_data;
         if (!wr_reissued)
            rs2_busy = 1'b0;
      end
`endif
   end

endmodule

// File: tb/tb_regfile.sv
// Self-checking bench for regfile: directed plan steps then random traffic against an array model.
module tb_regfile;

   localparam int unsigned XLEN  = 32;
   localparam int unsigned NREGS = 32;
   localparam int unsigned AW    = 5;

   logic            clk;
   logic            rst;
   logic [AW-1:0]   rs1_addr;
   logic [XLEN-1:0] rs1_data;
   logic            rs1_busy;
   logic [AW-1:0]   rs2_addr;
   logic [XLEN-1:0] rs2_data;
   logic            rs2_busy;
   logic            issue_en;
   logic [AW-1:0]   issue_rd;
   logic            we;
   logic [AW-1:0]   rd_addr;
   logic [XLEN-1:0] rd_data;

   int total = 0;
   int bad   = 0;

   logic [XLEN-1:0] m_regs [NREGS];
   bit              m_pend [NREGS];

   regfile #(
      .XLEN  (XLEN),
      .NREGS (NREGS),
      .AW    (AW)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .rs1_addr (rs1_addr),
      .rs1_data (rs1_data),
      .rs1_busy (rs1_busy),
      .rs2_addr (rs2_addr),
      .rs2_data (rs2_data),
      .rs2_busy (rs2_busy),
      .issue_en (issue_en),
      .issue_rd (issue_rd),
      .we       (we),
      .rd_addr  (rd_addr),
      .rd_data  (rd_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [XLEN-1:0] exp_data(input int a);
      if (a == 0) return '0;
`ifdef REGFILE_BYPASS_EN
      if (we && rd_addr != 0 && a == int'(rd_addr)) return rd_data;
`endif
      return m_regs[a];
   endfunction

   function automatic logic exp_busy(input int a);
      if (a == 0) return 1'b0;
`ifdef REGFILE_BYPASS_EN
      if (we && rd_addr != 0 && a == int'(rd_addr) && !(issue_en && issue_rd == rd_addr))
         return 1'b0;
`endif
      return m_pend[a];
   endfunction

   task automatic chk(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < int'(NREGS); i++) begin
         m_regs[i] = '0;
         m_pend[i] = 1'b0;
      end
   endtask

   // Apply inputs, then check all four read outputs against the model at the falling edge.
   task automatic drive_check(input logic r, input logic w, input int rd, input logic [XLEN-1:0] d,
                              input logic ie, input int ir, input int a1, input int a2);
      rst = r; we = w; rd_addr = AW'(rd); rd_data = d;
      issue_en = ie; issue_rd = AW'(ir);
      rs1_addr = AW'(a1); rs2_addr = AW'(a2);
      @(negedge clk);
      chk("rs1_data", rs1_data, exp_data(a1));
      chk("rs1_busy", {31'b0, rs1_busy}, {31'b0, exp_busy(a1)});
      chk("rs2_data", rs2_data, exp_data(a2));
      chk("rs2_busy", {31'b0, rs2_busy}, {31'b0, exp_busy(a2)});
   endtask

   task automatic edge_update();
      @(posedge clk);
      if (rst) begin
         model_reset();
      end else begin
         if (we && rd_addr != 0) begin
            m_regs[rd_addr] = rd_data;
            m_pend[rd_addr] = 1'b0;
         end
         if (issue_en && issue_rd != 0)
            m_pend[issue_rd] = 1'b1;
      end
      #1;
   endtask

   task automatic idle_read(input int a1, input int a2);
      drive_check(1'b0, 1'b0, 0, '0, 1'b0, 0, a1, a2);
   endtask

   initial begin
      model_reset();
      // Reset held while a write to x5 is presented.
      rst = 1'b1; we = 1'b1; rd_addr = 5; rd_data = 32'hDEADBEEF;
      issue_en = 1'b0; issue_rd = '0; rs1_addr = 5; rs2_addr = 0;
      @(posedge clk); @(posedge clk); #1;
      model_reset();

      idle_read(5, 5);
      chk("rst_x5_data", rs1_data, 32'h0);
      chk("rst_x5_busy", {31'b0, rs1_busy}, 32'h0);
      edge_update();

      for (int a = 0; a < int'(NREGS); a++) begin
         idle_read(a, int'(NREGS) - 1 - a);
         edge_update();
      end

      // Write x7, then read on both ports.
      drive_check(1'b0, 1'b1, 7, 32'h12345678, 1'b0, 0, 7, 7);
      edge_update();
      idle_read(7, 7);
      chk("x7_rs1", rs1_data, 32'h12345678);
      chk("x7_rs2", rs2_data, 32'h12345678);
      edge_update();

      // x0 is immune to writes and issues.
      drive_check(1'b0, 1'b1, 0, 32'hFFFFFFFF, 1'b0, 0, 0, 0);
      edge_update();
      drive_check(1'b0, 1'b0, 0, '0, 1'b1, 0, 0, 0);
      edge_update();
      idle_read(0, 0);
      chk("x0_data", rs1_data, 32'h0);
      chk("x0_busy", {31'b0, rs1_busy}, 32'h0);
      edge_update();

      // Issue x3, then write it back.
      drive_check(1'b0, 1'b0, 0, '0, 1'b1, 3, 3, 3);
      edge_update();
      idle_read(3, 3);
      chk("x3_busy_set", {31'b0, rs2_busy}, 32'h1);
      edge_update();
      drive_check(1'b0, 1'b1, 3, 32'hA5, 1'b0, 0, 3, 3);
      edge_update();
      idle_read(3, 3);
      chk("x3_busy_clr", {31'b0, rs2_busy}, 32'h0);
      chk("x3_data", rs2_data, 32'hA5);
      edge_update();

      // Same-cycle issue and write to x9: issue wins.
      drive_check(1'b0, 1'b1, 9, 32'h55, 1'b1, 9, 9, 9);
      edge_update();
      idle_read(9, 9);
      chk("x9_data", rs1_data, 32'h55);
      chk("x9_busy", {31'b0, rs1_busy}, 32'h1);
      edge_update();
      drive_check(1'b0, 1'b1, 9, 32'h66, 1'b0, 0, 9, 9);
      edge_update();
      idle_read(9, 9);
      chk("x9_busy_clr", {31'b0, rs1_busy}, 32'h0);
      edge_update();

      // Reset mid-flight with a competing write to x4.
      drive_check(1'b0, 1'b0, 0, '0, 1'b1, 4, 4, 4);
      edge_update();
      drive_check(1'b1, 1'b1, 4, 32'h1, 1'b0, 0, 4, 4);
      edge_update();
      idle_read(4, 4);
      chk("x4_rst_data", rs1_data, 32'h0);
      chk("x4_rst_busy", {31'b0, rs1_busy}, 32'h0);
      edge_update();

      // Random traffic; small address range raises collision rates.
      for (int n = 0; n < 600; n++) begin
         int hi;
         hi = ($urandom_range(0, 3) == 0) ? int'(NREGS) - 1 : 7;
         drive_check(($urandom_range(0, 79) == 0),
                     1'($urandom_range(0, 1)),
                     int'($urandom_range(0, hi)),
                     $urandom,
                     1'($urandom_range(0, 1)),
                     int'($urandom_range(0, hi)),
                     int'($urandom_range(0, hi)),
                     int'($urandom_range(0, hi)));
         edge_update();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
